decoder: RTL and testbench
==========================

# decoder

Receive-side counterpart of the 3-dimension orthogonal encoder. Slices three signed received samples (one per basis dimension) to the nearest constellation level index. Packs the indices back into the parallel data word with the same bit layout the encoder uses, and keeps symbol and clipping statistics. Sits after the channel/ADC front end and before the downstream data sink, with a valid/ready handshake on both sides.

## Interface
Parameters:
- BITS_WIDTH, 5: output word width; must equal DIM0_WIDTH+DIM1_WIDTH+DIM2_WIDTH.
- DIM0_WIDTH, 2: index bits of dimension 0 (M0 = 2^DIM0_WIDTH levels).
- DIM1_WIDTH, 2: index bits of dimension 1 (M1 = 4).
- DIM2_WIDTH, 1: index bits of dimension 2 (M2 = 2).
- SAMPLE_WIDTH, 8: width of each signed two's-complement input sample.
- STEP_LOG2, 4: half level spacing S = 2^STEP_LOG2. Nominal levels are (2k-M+1)*S for k = 0..M-1.
- CNT_WIDTH, 16: statistics counter width.

Ports:
- clk, input, 1: the single clock. All logic is on the rising edge.
- rst, input, 1: reset, synchronous and active-low. rst==0 at a rising edge resets the block.
- y0, y1, y2, input, SAMPLE_WIDTH each: signed received samples for dimensions 0, 1, 2.
- in_valid, input, 1: y0..y2 hold a symbol.
- in_ready, output, 1: block can accept; combinational.
- data, output, BITS_WIDTH: decoded word. data[DIM0_WIDTH-1:0]=k0, next DIM1_WIDTH bits=k1, top DIM2_WIDTH bits=k2.
- out_valid, output, 1: data holds a decoded symbol.
- out_ready, input, 1: sink accepts data.
- clipped, output, 1: qualifies data; at least one dimension of this symbol was clipped.
- cnt_clr, input, 1: synchronous clear of both counters.
- sym_count, output, CNT_WIDTH: symbols delivered (out_valid && out_ready); wraps modulo 2^CNT_WIDTH.
- clip_count, output, CNT_WIDTH: delivered symbols with clipped=1; saturates at all-ones.

## Operation
- Per dimension n, raw index r = (y + M*S) >>> (STEP_LOG2+1). The shift is arithmetic.
  - Computed in signed width SAMPLE_WIDTH+DIMn_WIDTH+STEP_LOG2+2; no overflow is possible.
  - Ties at a decision boundary resolve to the higher index.
- Index k = clamp(r, 0, M-1). Dimension clip flag = (r<0) || (r>M-1).
- Two-stage pipeline:
  - Stage 1 registers the three raw indices r and a valid bit.
  - Stage 2 (output registers) registers the clamped and packed data, clipped, and out_valid.
- Advance condition: adv = out_ready || !out_valid. in_ready = adv && rst.
- When adv=1 at an edge:
  - Stage 1 loads y-derived r, with valid = in_valid.
  - Stage 2 loads from stage 1.
- When adv=0, both stages hold. Bubbles are not squeezed out while stalled.
- Counters update at an edge where out_valid && out_ready:
  - sym_count increments.
  - clip_count increments if clipped and not already all-ones.
- cnt_clr=1 zeroes both counters at that edge. Clear wins over a simultaneous increment.

## Timing
- Reset (rst==0 at an edge), all outputs and state go to 0:
  - out_valid=0, data=0, clipped=0.
  - Stage-1 valid and raw indices = 0.
  - sym_count=0, clip_count=0.
- in_ready=0 while rst==0.
- Latency: a symbol accepted at edge n (in_valid && in_ready) appears with out_valid=1 after edge n+1, if adv held at n+1.
- Throughput: one symbol per clock with out_ready held high.
- Backpressure:
  - data, clipped, and out_valid are stable while out_valid && !out_ready.
  - The stalled word is held until the edge where out_ready=1.
- Reset mid-operation discards both in-flight symbols. Counters are not incremented at the reset edge even if out_ready=1.
- in_valid is ignored when in_ready=0. The source must hold the symbol.

## Test plan
Default parameters (S=16, dim0/1 levels -48,-16,16,48; dim2 levels -16,16).
- Nominal symbol: y0=-48, y1=16, y2=16, one valid pulse, out_ready=1.
  - Expect data=5'b11000 (k0=0, k1=2, k2=1) and clipped=0 two edges after acceptance.
  - Expect sym_count=1, clip_count=0.
- Boundaries: y0=0 -> k0=2; y0=-1 -> k0=1; y0=-33 -> k0=0; y0=-32 -> k0=1; y2=0 -> k2=1; y2=-1 -> k2=0.
- Clipping:
  - y0=127 -> k0=3 with clipped=1; y0=-128 -> k0=0 with clipped=1.
  - y0=63 -> k0=3 with clipped=0; y0=64 -> clipped=1.
  - clip_count counts only clipped deliveries.
- Backpressure: stream 4 symbols with out_ready low for 3 cycles mid-stream.
  - in_ready drops while stalled; output holds stable.
  - All 4 words delivered in order, none lost or duplicated; sym_count=4.
- Counters:
  - cnt_clr asserted on the same edge as a delivery -> both counters read 0 afterwards.
  - Preload-by-stimulus with CNT_WIDTH=4: clip_count saturates at 15; sym_count wraps 15 -> 0.
- Reset: assert rst=0 with two symbols in flight and out_ready=1.
  - Next cycle out_valid=0, data=0, counters 0, in_ready=0.
  - After release, the next symbol decodes normally with 2-cycle latency.

Source files
------------

// File: rtl/decoder.sv
// Slicer/decoder for the 3-dimension orthogonal code: maps three signed samples to
// level indices, packs them into the data word and tracks delivery/clip statistics.
module decoder #(
  parameter int BITS_WIDTH   = 5,
  parameter int DIM0_WIDTH   = 2,
  parameter int DIM1_WIDTH   = 2,
  parameter int DIM2_WIDTH   = 1,
  parameter int SAMPLE_WIDTH = 8,
  parameter int STEP_LOG2    = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [SAMPLE_WIDTH-1:0] y0,
  input  logic signed [SAMPLE_WIDTH-1:0] y1,
  input  logic signed [SAMPLE_WIDTH-1:0] y2,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [BITS_WIDTH-1:0]          data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           clipped,
  input  logic                           cnt_clr,
  output logic [CNT_WIDTH-1:0]           sym_count,
  output logic [CNT_WIDTH-1:0]           clip_count
);

  localparam int RW0 = SAMPLE_WIDTH + DIM0_WIDTH + STEP_LOG2 + 2;
  localparam int RW1 = SAMPLE_WIDTH + DIM1_WIDTH + STEP_LOG2 + 2;
  localparam int RW2 = SAMPLE_WIDTH + DIM2_WIDTH + STEP_LOG2 + 2;

  // Offset M*S moves the lowest decision region to start at zero.
  localparam logic signed [RW0-1:0] OFF0 = RW0'(1'b1) << (DIM0_WIDTH + STEP_LOG2);
  localparam logic signed [RW1-1:0] OFF1 = RW1'(1'b1) << (DIM1_WIDTH + STEP_LOG2);
  localparam logic signed [RW2-1:0] OFF2 = RW2'(1'b1) << (DIM2_WIDTH + STEP_LOG2);
  localparam logic signed [RW0-1:0] MAX0 = (RW0'(1'b1) << DIM0_WIDTH) - RW0'(1'b1);
  localparam logic signed [RW1-1:0] MAX1 = (RW1'(1'b1) << DIM1_WIDTH) - RW1'(1'b1);
  localparam logic signed [RW2-1:0] MAX2 = (RW2'(1'b1) << DIM2_WIDTH) - RW2'(1'b1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic signed [RW0-1:0] y0_ext_s, raw0_s, raw0_r;
  logic signed [RW1-1:0] y1_ext_s, raw1_s, raw1_r;
  logic signed [RW2-1:0] y2_ext_s, raw2_s, raw2_r;
  logic                  v1_r;
  logic [DIM0_WIDTH-1:0] k0_s;
  logic [DIM1_WIDTH-1:0] k1_s;
  logic [DIM2_WIDTH-1:0] k2_s;
  logic                  clip0_s, clip1_s, clip2_s;
  logic                  adv_s;
  logic [BITS_WIDTH-1:0] data_r;
  logic                  out_valid_r, clipped_r;
  logic [CNT_WIDTH-1:0]  sym_count_r, clip_count_r;

  assign adv_s     = out_ready || !out_valid_r;
  assign in_ready  = adv_s && rst;
  assign data      = data_r;
  assign out_valid = out_valid_r;
  assign clipped   = clipped_r;
  assign sym_count = sym_count_r;
  assign clip_count = clip_count_r;

  // Raw index: arithmetic shift floors, so ties land on the higher index.
  always_comb begin
    y0_ext_s = {{(RW0-SAMPLE_WIDTH){y0[SAMPLE_WIDTH-1]}}, y0};
    y1_ext_s = {{(RW1-SAMPLE_WIDTH){y1[SAMPLE_WIDTH-1]}}, y1};
    y2_ext_s = {{(RW2-SAMPLE_WIDTH){y2[SAMPLE_WIDTH-1]}}, y2};
    raw0_s   = (y0_ext_s + OFF0) >>> (STEP_LOG2 + 1);
    raw1_s   = (y1_ext_s + OFF1) >>> (STEP_LOG2 + 1);
    raw2_s   = (y2_ext_s + OFF2) >>> (STEP_LOG2 + 1);
  end

  // Clamp each stage-1 raw index into [0, M-1] and flag out-of-range values.
  always_comb begin
    k0_s = '0; clip0_s = 1'b0;
    k1_s = '0; clip1_s = 1'b0;
    k2_s = '0; clip2_s = 1'b0;
    if (raw0_r[RW0-1]) begin
      k0_s = '0; clip0_s = 1'b1;
    end else if (raw0_r > MAX0) begin
      k0_s = '1; clip0_s = 1'b1;
    end else begin
      k0_s = raw0_r[DIM0_WIDTH-1:0]; clip0_s = 1'b0;
    end
    if (raw1_r[RW1-1]) begin
      k1_s = '0; clip1_s = 1'b1;
    end else if (raw1_r > MAX1) begin
      k1_s = '1; clip1_s = 1'b1;
    end else begin
      k1_s = raw1_r[DIM1_WIDTH-1:0]; clip1_s = 1'b0;
    end
    if (raw2_r[RW2-1]) begin
      k2_s = '0; clip2_s = 1'b1;
    end else if (raw2_r > MAX2) begin
      k2_s = '1; clip2_s = 1'b1;
    end else begin
      k2_s = raw2_r[DIM2_WIDTH-1:0]; clip2_s = 1'b0;
    end
  end

  // Two-stage pipeline; both stages move together only when the output can advance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_r        <= 1'b0;
      raw0_r      <= '0;
      raw1_r      <= '0;
      raw2_r      <= '0;
      out_valid_r <= 1'b0;
      data_r      <= '0;
      clipped_r   <= 1'b0;
    end else if (adv_s) begin
      v1_r        <= in_valid;
      raw0_r      <= raw0_s;
      raw1_r      <= raw1_s;
      raw2_r      <= raw2_s;
      out_valid_r <= v1_r;
      data_r      <= {k2_s, k1_s, k0_s};
      clipped_r   <= clip0_s || clip1_s || clip2_s;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Delivery statistics: symbol count wraps, clip count saturates, clear has priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sym_count_r  <= '0;
      clip_count_r <= '0;
    end else if (cnt_clr) begin
      sym_count_r  <= '0;
      clip_count_r <= '0;
    end else if (out_valid_r && out_ready) begin
      sym_count_r <= sym_count_r + CNT_ONE;
      if (clipped_r && !(&clip_count_r)) begin
        clip_count_r <= clip_count_r + CNT_ONE;
      end else begin
        clip_count_r <= clip_count_r;
      end
    end else begin
      sym_count_r <= sym_count_r;
    end
  end

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: directed vector table, multi-cycle corner sequences
// and randomized traffic against a nearest-level reference model with a scoreboard.
module tb_decoder;

  localparam int S  = 16;
  localparam int CW = 4;

  logic clk, rst, in_valid, in_ready, out_valid, out_ready, clipped, cnt_clr;
  logic signed [7:0] y0, y1, y2;
  logic [4:0] data;
  logic [CW-1:0] sym_count, clip_count;

  int checks = 0;
  int errors = 0;

  decoder #(.BITS_WIDTH(5), .DIM0_WIDTH(2), .DIM1_WIDTH(2), .DIM2_WIDTH(1),
            .SAMPLE_WIDTH(8), .STEP_LOG2(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .y0(y0), .y1(y1), .y2(y2),
    .in_valid(in_valid), .in_ready(in_ready), .data(data), .out_valid(out_valid),
    .out_ready(out_ready), .clipped(clipped), .cnt_clr(cnt_clr),
    .sym_count(sym_count), .clip_count(clip_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: nearest nominal level, ties to the higher index.
  function automatic int ref_idx(input int y, input int m);
    int best, bestd, d, lvl;
    best = 0;
    bestd = 1 << 30;
    for (int k = 0; k < m; k++) begin
      lvl = (2 * k - m + 1) * S;
      d = (y > lvl) ? y - lvl : lvl - y;
      if (d <= bestd) begin
        best = k;
        bestd = d;
      end
    end
    return best;
  endfunction

  // A sample is clipped when it lies outside every decision region.
  function automatic bit ref_clip(input int y, input int m);
    return (y < -m * S) || (y >= m * S);
  endfunction

  typedef struct { int d; int c; } exp_t;
  exp_t q[$];
  int  m_sym, m_clip;
  bit  m_known = 1'b0;
  bit  prev_stall = 1'b0;
  int  prev_data, prev_clip;

  // Scoreboard, counter model and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e, got;
    if (prev_stall) begin
      check("hold_valid", int'(out_valid), 1);
      check("hold_data", int'(data), prev_data);
      check("hold_clip", int'(clipped), prev_clip);
    end
    if (m_known) begin
      check("sym_count", int'(sym_count), m_sym);
      check("clip_count", int'(clip_count), m_clip);
    end
    if (!rst) begin
      q.delete();
      m_sym = 0;
      m_clip = 0;
      m_known = 1'b1;
      prev_stall = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_spurious: got data %0d, expected no delivery", data);
        end else begin
          e = q.pop_front();
          check("sb_data", int'(data), e.d);
          check("sb_clip", int'(clipped), e.c);
        end
      end
      if (in_valid && in_ready) begin
        got.d = ref_idx(int'(y0), 4) + 4 * ref_idx(int'(y1), 4) + 16 * ref_idx(int'(y2), 2);
        got.c = int'(ref_clip(int'(y0), 4) || ref_clip(int'(y1), 4) || ref_clip(int'(y2), 2));
        q.push_back(got);
      end
      if (cnt_clr) begin
        m_sym = 0;
        m_clip = 0;
      end else if (out_valid && out_ready) begin
        m_sym = (m_sym + 1) % (1 << CW);
        if (clipped && m_clip < (1 << CW) - 1) m_clip = m_clip + 1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = int'(data);
      prev_clip = int'(clipped);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [7:0] a, input logic signed [7:0] b,
                      input logic signed [7:0] c);
    int n;
    bit acc;
    y0 = a; y1 = b; y2 = c;
    in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no in_ready, expected acceptance within 50 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      tick();
      n++;
    end
    if (q.size() != 0 || out_valid) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
    end
  endtask

  task automatic clear_counters();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  typedef struct {
    logic signed [7:0] a, b, c;
    logic [4:0] d;
    logic cl;
  } vec_t;
  vec_t vt[11];
  bit rnd_done;

  initial begin
    vt[0]  = '{-48,  16,  16, 5'b11000, 1'b0};
    vt[1]  = '{  0, -48, -16, 5'b00010, 1'b0};
    vt[2]  = '{ -1,  48,   0, 5'b11101, 1'b0};
    vt[3]  = '{-33, -16,  -1, 5'b00100, 1'b0};
    vt[4]  = '{-32,   0,  15, 5'b11001, 1'b0};
    vt[5]  = '{127,   0,   0, 5'b11011, 1'b1};
    vt[6]  = '{-128,  0,   0, 5'b11000, 1'b1};
    vt[7]  = '{ 63, -64,   0, 5'b10011, 1'b0};
    vt[8]  = '{ 64,   0, -33, 5'b01011, 1'b1};
    vt[9]  = '{  0,   0,  32, 5'b11010, 1'b1};
    vt[10] = '{  0,  63, -32, 5'b01110, 1'b0};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    y0 = '0; y1 = '0; y2 = '0;
    repeat (3) tick();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_data", int'(data), 0);
    check("rst_in_ready", int'(in_ready), 0);
    rst = 1'b1;
    tick();

    // Directed vectors, each with exact two-edge latency.
    for (int i = 0; i < 11; i++) begin
      send(vt[i].a, vt[i].b, vt[i].c);
      check($sformatf("vec%0d_early", i), int'(out_valid), 0);
      tick();
      check($sformatf("vec%0d_valid", i), int'(out_valid), 1);
      check($sformatf("vec%0d_data", i), int'(data), int'(vt[i].d));
      check($sformatf("vec%0d_clip", i), int'(clipped), int'(vt[i].cl));
    end
    wait_idle();
    check("table_sym", int'(sym_count), 11);
    check("table_clips", int'(clip_count), 4);

    // Backpressure: four symbols, three stalled cycles mid-stream.
    clear_counters();
    fork
      begin
        send(8'sd10, 8'sd20, -8'sd5);
        send(-8'sd60, 8'sd100, 8'sd1);
        send(8'sd33, -8'sd17, 8'sd40);
        send(-8'sd90, 8'sd0, -8'sd20);
      end
      begin
        repeat (2) tick();
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check("bp_in_ready", int'(in_ready), 0);
          check("bp_out_valid", int'(out_valid), 1);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    wait_idle();
    check("bp_sym", int'(sym_count), 4);

    // Clear on the same edge as a delivery.
    send(-8'sd48, 8'sd16, 8'sd16);
    tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_sym", int'(sym_count), 0);
    check("clr_clip", int'(clip_count), 0);

    // Saturation of clip_count and wrap of sym_count.
    for (int i = 0; i < 20; i++) send(8'sd127, 8'sd0, 8'sd0);
    wait_idle();
    check("wrap_sym", int'(sym_count), 4);
    check("sat_clip", int'(clip_count), 15);

    // Randomized traffic with random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)));
          repeat ($urandom_range(0, 2)) tick();
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    wait_idle();
    check("sb_empty", q.size(), 0);

    // Reset with two symbols in flight.
    send(8'sd48, 8'sd48, 8'sd16);
    y0 = -8'sd16; y1 = -8'sd16; y2 = -8'sd16; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("mrst_out_valid", int'(out_valid), 0);
    check("mrst_data", int'(data), 0);
    check("mrst_sym", int'(sym_count), 0);
    check("mrst_clip", int'(clip_count), 0);
    check("mrst_in_ready", int'(in_ready), 0);
    rst = 1'b1;
    send(8'sd16, -8'sd16, -8'sd16);
    check("post_rst_early", int'(out_valid), 0);
    tick();
    check("post_rst_valid", int'(out_valid), 1);
    check("post_rst_data", int'(data), 5'b00110);
    tick();
    check("post_rst_sym", int'(sym_count), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
